// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: core width, AXI response
// codes, reset fetch address and fetch FSM state encoding.
package instruction_fetch_unit_pkg;

    localparam int CORE_XLEN = 32;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [CORE_XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_ADDR = 2'd1,
        FETCH_DATA = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with a flush that overrides any push or pop in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic                     i_Clock,
    input  logic                     w_Reset,
    input  logic                     i_Flush,
    input  logic                     i_Push,
    input  logic [WIDTH-1:0]         i_Push_Data,
    input  logic                     i_Pop,
    output logic [WIDTH-1:0]         o_Head,
    output logic [$clog2(DEPTH):0]   o_Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] r_Mem [DEPTH];
    logic [PTR_W-1:0] r_Wr_Ptr;
    logic [PTR_W-1:0] r_Rd_Ptr;
    logic [PTR_W:0]   r_Count;
    logic             w_Do_Push;
    logic             w_Do_Pop;

    assign w_Do_Push = i_Push && !i_Flush && (r_Count != FULL_COUNT);
    assign w_Do_Pop  = i_Pop  && !i_Flush && (r_Count != '0);

    always_ff @(posedge i_Clock) begin
        if (w_Reset || i_Flush) begin
            r_Wr_Ptr <= '0;
            r_Rd_Ptr <= '0;
            r_Count  <= '0;
        end else begin
            if (w_Do_Push) r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
            if (w_Do_Pop)  r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
            case ({w_Do_Push, w_Do_Pop})
                2'b10:   r_Count <= r_Count + 1'b1;
                2'b01:   r_Count <= r_Count - 1'b1;
                default: r_Count <= r_Count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge i_Clock) begin
        if (w_Do_Push) r_Mem[r_Wr_Ptr] <= i_Push_Data;
    end

    assign o_Head  = r_Mem[r_Rd_Ptr];
    assign o_Count = r_Count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// AXI4-Lite instruction fetch master: prefetches sequential words into a small
// FIFO, one outstanding read at a time, with redirect flush and response discard.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                XLEN       = CORE_XLEN,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0]   RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic             i_Clock,
    input  logic             w_Reset,
    input  logic             i_Enable,
    input  logic             i_Redirect,
    input  logic [XLEN-1:0]  i_Redirect_PC,
    input  logic             i_Instruction_Ready,
    output logic [XLEN-1:0]  o_Instruction,
    output logic [XLEN-1:0]  o_Instruction_PC,
    output logic             o_Instruction_Valid,
    output logic             o_Fetch_Error,
    output logic [XLEN-1:0]  s_axil_araddr,
    output logic             s_axil_arvalid,
    input  logic             s_axil_arready,
    input  logic [XLEN-1:0]  s_axil_rdata,
    input  logic [1:0]       s_axil_rresp,
    input  logic             s_axil_rvalid,
    output logic             s_axil_rready
);

    localparam int ENTRY_W = 2 * XLEN + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_COUNT = FIFO_DEPTH[CNT_W-1:0];

    fetch_state_t     r_State;
    fetch_state_t     w_Next_State;
    logic [XLEN-1:0]  r_Fetch_PC;
    logic [XLEN-1:0]  r_Araddr;
    logic             r_Discard;

    logic [CNT_W-1:0]   w_Count;
    logic [ENTRY_W-1:0] w_Head;
    logic [ENTRY_W-1:0] w_Push_Data;
    logic [XLEN-1:0]    w_Redirect_PC;
    logic               w_Issue;
    logic               w_Beat;
    logic               w_Push;
    logic               w_Pop;

    assign w_Redirect_PC = i_Redirect_PC & ~XLEN'(3);

    // Issue only with a free slot so a returning beat can always be pushed.
    assign w_Issue = (r_State == FETCH_IDLE) && i_Enable && !i_Redirect && (w_Count < DEPTH_COUNT);
    assign w_Beat  = (r_State == FETCH_DATA) && s_axil_rvalid;
    assign w_Push  = w_Beat && !r_Discard && !i_Redirect;
    assign w_Pop   = o_Instruction_Valid && i_Instruction_Ready;

    always_ff @(posedge i_Clock) begin
        if (w_Reset) r_State <= FETCH_IDLE;
        else         r_State <= w_Next_State;
    end

    always_comb begin
        w_Next_State = r_State;
        case (r_State)
            FETCH_IDLE: if (w_Issue)        w_Next_State = FETCH_ADDR;
            FETCH_ADDR: if (s_axil_arready) w_Next_State = FETCH_DATA;
            FETCH_DATA: if (s_axil_rvalid)  w_Next_State = FETCH_IDLE;
            default:                        w_Next_State = FETCH_IDLE;
        endcase
    end

    // A redirect while a read is outstanding marks its beat as stale.
    always_ff @(posedge i_Clock) begin
        if (w_Reset) begin
            r_Fetch_PC <= RESET_PC;
            r_Araddr   <= '0;
            r_Discard  <= 1'b0;
        end else begin
            if (w_Issue) r_Araddr <= r_Fetch_PC;
            if (i_Redirect)  r_Fetch_PC <= w_Redirect_PC;
            else if (w_Push) r_Fetch_PC <= r_Fetch_PC + XLEN'(4);
            if (w_Beat) r_Discard <= 1'b0;
            else if (i_Redirect && (r_State != FETCH_IDLE)) r_Discard <= 1'b1;
        end
    end

    assign w_Push_Data = {s_axil_rdata, r_Araddr, (s_axil_rresp != RESP_OKAY)};

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .i_Clock     (i_Clock),
        .w_Reset     (w_Reset),
        .i_Flush     (i_Redirect),
        .i_Push      (w_Push),
        .i_Push_Data (w_Push_Data),
        .i_Pop       (w_Pop),
        .o_Head      (w_Head),
        .o_Count     (w_Count)
    );

    assign o_Instruction_Valid = (w_Count != '0);
    assign o_Instruction       = o_Instruction_Valid ? w_Head[ENTRY_W-1 -: XLEN] : '0;
    assign o_Instruction_PC    = o_Instruction_Valid ? w_Head[XLEN:1] : '0;
    assign o_Fetch_Error       = o_Instruction_Valid && w_Head[0];

    assign s_axil_araddr  = r_Araddr;
    assign s_axil_arvalid = (r_State == FETCH_ADDR);
    assign s_axil_rready  = (r_State == FETCH_DATA);

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
AXI4-Lite read master with a small prefetch FIFO. It sits directly upstream of the core's decode/execute stage (stage 1) and replaces the single-shot instruction memory adapter. It fetches sequential words ahead of the consumer and presents one instruction plus its PC with a valid/ready handshake. Branch/jump redirects flush the buffer and discard any in-flight response.

Parameters:
XLEN, 32, data/address width
FIFO_DEPTH, 2, prefetch entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
i_Clock  in  1  clock
w_Reset  in  1  reset; synchronous, active-high
i_Enable  in  1  memory calibrated; low blocks new AR issue only
i_Redirect  in  1  flush and refetch from i_Redirect_PC
i_Redirect_PC  in  XLEN  new fetch address; bits [1:0] ignored (forced 0)
i_Instruction_Ready  in  1  consumer accepts head entry
o_Instruction  out  XLEN  head instruction word
o_Instruction_PC  out  XLEN  address of head instruction
o_Instruction_Valid  out  1  FIFO non-empty
o_Fetch_Error  out  1  head entry returned RRESP != OKAY
s_axil_araddr  out  XLEN  read address
s_axil_arvalid  out  1  read address valid
s_axil_arready  in  1  read address ready
s_axil_rdata  in  XLEN  read data
s_axil_rresp  in  2  read response
s_axil_rvalid  in  1  read data valid
s_axil_rready  out  1  read data ready

Behaviour:
- Reset: FSM=IDLE, r_Fetch_PC=RESET_PC, FIFO count=0, discard flag=0, arvalid=0, rready=0, o_Instruction_Valid=0, o_Fetch_Error=0; o_Instruction/o_Instruction_PC=0.
- FSM states:
  - IDLE -> ADDR when i_Enable && !i_Redirect && (count + 0) < FIFO_DEPTH. Entering ADDR drives araddr=r_Fetch_PC, arvalid=1.
  - ADDR: hold arvalid and araddr stable until arready; then -> DATA with rready=1.
  - DATA: on rvalid -> IDLE. If discard=0, push {rdata, araddr, rresp!=0} and r_Fetch_PC += 4. If discard=1, drop the beat and clear discard.
- At most one outstanding read. Issue is gated so a push always finds space; overflow is impossible.
- Output path:
  - Head of FIFO drives o_Instruction, o_Instruction_PC and o_Fetch_Error combinationally.
  - Pop on o_Instruction_Valid && i_Instruction_Ready.
  - Push and pop in the same cycle: count unchanged.
- Latency: a push in cycle N gives o_Instruction_Valid=1 in cycle N+1. With zero-wait memory (arready same cycle, rvalid next cycle), first valid appears 3 cycles after reset release.
- Redirect (highest priority, single-cycle pulse):
  - FIFO count <= 0, pointers reset, r_Fetch_PC <= {i_Redirect_PC[XLEN-1:2], 2'b00}.
  - Any pop or push in the same cycle is cancelled.
  - In IDLE: next AR uses the new PC.
  - In ADDR: arvalid is never retracted; the transaction completes with discard=1.
  - In DATA without rvalid: discard=1.
  - In DATA with rvalid in the same cycle: beat dropped, -> IDLE.
- i_Enable low: no new ADDR entry; an in-flight transaction completes normally and the FIFO remains poppable.
- r_Fetch_PC wraps modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
- Error: a faulting beat is buffered like data with o_Fetch_Error=1. The consumer decides the trap; fetch continues sequentially.
- Reset mid-transaction forces IDLE immediately. The AXI interconnect shares w_Reset.

Decomposition:
- Shared package/header: fetch FSM state encodings (IDLE/ADDR/DATA), AXI RESP_OKAY constant, RESET_PC default, XLEN from core params.
- One sub-module: fetch_fifo (synchronous FIFO, width 2*XLEN+1, flush input, count output), reusable for the data path later.

Test Plan:
- Reset release, zero-wait slave with mem[0]=0x00000013, mem[4]=0x00100093, Ready=1 -> valid at cycle 3 with {0x13, PC 0}, next {0x00100093, PC 4}, araddr sequence 0,4,8.
- Ready=0 held -> exactly FIFO_DEPTH ARs (0x0, 0x4), arvalid stays 0 after. Ready=1 for one cycle -> one pop, then AR at 0x8.
- Redirect to 0x100 while arvalid=1 and arready=0 for 3 cycles -> araddr stays at the old value until handshake, beat dropped, next AR=0x100, first output PC=0x100.
- Redirect in the same cycle as rvalid and a pop -> FIFO empty next cycle, beat not buffered, next AR=redirect PC.
- Slave returns rresp=2'b10 at 0x8 -> o_Fetch_Error=1 with PC 0x8, then AR 0xC with error cleared on the following entry.
- i_Enable dropped during DATA -> response still buffered, no further AR until i_Enable=1. Reset asserted mid-ADDR -> arvalid=0 and count=0 next cycle, refetch from RESET_PC.
